echo_ranging_ctrl: RTL and testbench
====================================

Name: echo_ranging_ctrl

Overview:
- Sequencer for one ultrasonic ranging channel.
- Fires a trigger pulse at the transducer and watches the echo-capture block's done flag through the echo's rise and fall.
- Latches the captured echo width and presents it on a valid/ready result port.
- Supports single-shot and free-running (periodic) operation, with timeout on a missing or stuck echo. Sits between the capture block and the host/readout logic.

Parameters:
OUT_LEN, 8, width of capture count input and result data
TMR_W, 16, width of internal timer
TRIG_CYCLES, 10, trigger high time in clk cycles (>=1)
TIMEOUT_CYCLES, 38000, max cycles allowed in each echo-wait state (<2^TMR_W)
HOLDOFF_CYCLES, 60000, dead time after a result before next trigger (>=1, <2^TMR_W)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  single-shot request, sampled in IDLE
cont_en  input  1  free-running mode enable
cap_done  input  1  done flag from capture block (1 = idle, 0 = measuring)
cap_cnt  input  OUT_LEN  echo width from capture block
trig  output  1  trigger to transducer
busy  output  1  high whenever state != IDLE
result_data  output  OUT_LEN  measured width, or all ones on timeout
result_timeout  output  1  qualifies result_data as a timeout
result_valid  output  1  result available
result_ready  input  1  consumer accepts result

Behaviour:
- Reset values: state IDLE, timer 0, trig 0, busy 0, result_data 0, result_timeout 0, result_valid 0. Reset asserted mid-operation drops trig immediately (asynchronous), discards the measurement, and returns to IDLE.
- States: IDLE, TRIG, WAIT_RISE, WAIT_FALL, LATCH, HOLDOFF.
- IDLE:
  - Launch condition: (start | cont_en) & cap_done & !result_valid.
  - On launch, go to TRIG with timer cleared.
  - start not accepted is dropped, not queued.
  - cap_done=0 in IDLE (capture still busy, or capture just out of reset) blocks launch.
- TRIG:
  - trig=1 for exactly TRIG_CYCLES clk cycles; it is registered, so it rises the cycle after launch.
  - Then go to WAIT_RISE, timer cleared.
- WAIT_RISE:
  - cap_done==0 -> WAIT_FALL, timer cleared.
  - Otherwise timer++.
  - Timer == TIMEOUT_CYCLES-1 with cap_done still 1 -> timeout.
- WAIT_FALL:
  - cap_done==1 -> LATCH.
  - Otherwise timer++.
  - Same timeout rule as WAIT_RISE.
- LATCH:
  - One cycle of settling for the capture output register.
  - Then result_data <= cap_cnt, result_timeout <= 0, result_valid <= 1, go to HOLDOFF with timer cleared.
- Timeout: result_data <= all ones, result_timeout <= 1, result_valid <= 1, go to HOLDOFF.
- HOLDOFF: counts HOLDOFF_CYCLES, then IDLE. Independent of the handshake.
- Handshake:
  - result_valid stays high, with data stable, until the cycle where result_valid & result_ready; it clears on the next edge.
  - At most one result is outstanding, because launch requires !result_valid. In cont_en mode an unconsumed result stalls in IDLE (backpressure, no overwrite).
- cont_en deasserted mid-measurement: the current measurement completes normally, then no relaunch.
- No arithmetic on cap_cnt. The count is passed through unchanged, including a wrapped capture value.

Optional Feature:
- Macro: UDAR_CTRL_AVG_EN.
- When defined, the block averages 4 measurements per result:
  - Four consecutive non-timeout measurements are accumulated in an (OUT_LEN+2)-bit sum.
  - After the 4th: result_data = sum[OUT_LEN+1:2] (truncating), result_valid set, sum and index cleared.
  - Measurements 1-3 do not raise result_valid. The next launch follows HOLDOFF directly, and the !result_valid check still applies.
  - A timeout clears the sum and index and reports the timeout immediately.
- When not defined: one measurement per result, no accumulator logic.

Test Plan:
1. Reset release, cap_done=1, start pulse -> trig high exactly 10 cycles starting the cycle after start; echo held 25 cycles with capture cnt=25 -> result_valid=1, result_data=25, result_timeout=0; hold result_ready=0 for 5 cycles -> data stable; result_ready=1 -> valid clears next edge.
2. No echo after trigger (TIMEOUT_CYCLES=100) -> result_valid rises 100 cycles after WAIT_RISE entry; result_data=0xFF, result_timeout=1.
3. Echo stuck high -> WAIT_FALL times out after 100 cycles, data=0xFF, timeout=1; start while cap_done=0 is ignored; trig stays 0.
4. cont_en=1, result_ready=1 held -> trigger pulses spaced by trig+echo+LATCH+HOLDOFF cycles; with result_ready=0 -> exactly one result, then block stays in IDLE, no further trig until accept.
5. Assert rst during TRIG and during WAIT_FALL -> trig drops the same cycle; all outputs return to reset values; a fresh start then produces a correct measurement.
6. With UDAR_CTRL_AVG_EN: widths 10,11,12,14 -> single result 11; widths 10 then timeout -> timeout result, and the next 4 measurements average afresh.

Source files
------------

// File: rtl/echo_ranging_ctrl.sv
// rtl/echo_ranging_ctrl.sv - ultrasonic ranging sequencer: trigger, echo wait, latch, holdoff, valid/ready result
// Optional UDAR_CTRL_AVG_EN: report the truncated mean of four consecutive measurements.
module echo_ranging_ctrl #(
    parameter int OUT_LEN        = 8,
    parameter int TMR_W          = 16,
    parameter int TRIG_CYCLES    = 10,
    parameter int TIMEOUT_CYCLES = 38000,
    parameter int HOLDOFF_CYCLES = 60000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cont_en,
    input  logic               cap_done,
    input  logic [OUT_LEN-1:0] cap_cnt,
    output logic               trig,
    output logic               busy,
    output logic [OUT_LEN-1:0] result_data,
    output logic               result_timeout,
    output logic               result_valid,
    input  logic               result_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_WAIT_FALL, S_LATCH, S_HOLDOFF
    } state_t;

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_CYCLES - 1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               trig_q;
    logic [OUT_LEN-1:0] data_q, data_d;
    logic               tout_q, tout_d;
    logic               valid_q, valid_d;
    logic               to_hit;

`ifdef UDAR_CTRL_AVG_EN
    logic [OUT_LEN+1:0] sum_q, sum_d;
    logic [1:0]         idx_q, idx_d;
    logic [OUT_LEN+1:0] acc;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        tout_d  = tout_q;
        valid_d = valid_q;
        to_hit  = 1'b0;
`ifdef UDAR_CTRL_AVG_EN
        sum_d = sum_q;
        idx_d = idx_q;
        acc   = sum_q + {2'b00, cap_cnt};
`endif
        if (valid_q && result_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if ((start || cont_en) && cap_done && !valid_q) begin
                    state_d = S_TRIG;
                    timer_d = '0;
                end
            end
            S_TRIG: begin
                if (timer_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_RISE: begin
                if (!cap_done) begin
                    state_d = S_WAIT_FALL;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    to_hit = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WAIT_FALL: begin
                if (cap_done) begin
                    state_d = S_LATCH;
                end else if (timer_q == TO_LAST) begin
                    to_hit = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_LATCH: begin
                // cap_cnt has had one cycle to settle after done rose
                state_d = S_HOLDOFF;
                timer_d = '0;
`ifdef UDAR_CTRL_AVG_EN
                if (idx_q == 2'd3) begin
                    data_d  = acc[OUT_LEN+1:2];
                    tout_d  = 1'b0;
                    valid_d = 1'b1;
                    sum_d   = '0;
                    idx_d   = '0;
                end else begin
                    sum_d = acc;
                    idx_d = idx_q + 2'd1;
                end
`else
                data_d  = cap_cnt;
                tout_d  = 1'b0;
                valid_d = 1'b1;
`endif
            end
            S_HOLDOFF: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        if (to_hit) begin
            state_d = S_HOLDOFF;
            timer_d = '0;
            data_d  = '1;
            tout_d  = 1'b1;
            valid_d = 1'b1;
`ifdef UDAR_CTRL_AVG_EN
            sum_d = '0;
            idx_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            trig_q  <= 1'b0;
            data_q  <= '0;
            tout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            trig_q  <= (state_d == S_TRIG);
            data_q  <= data_d;
            tout_q  <= tout_d;
            valid_q <= valid_d;
        end
    end

`ifdef UDAR_CTRL_AVG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            idx_q <= '0;
        end else begin
            sum_q <= sum_d;
            idx_q <= idx_d;
        end
    end
`endif

    assign trig           = trig_q;
    assign busy           = (state_q != S_IDLE);
    assign result_data    = data_q;
    assign result_timeout = tout_q;
    assign result_valid   = valid_q;

endmodule

// File: tb/tb_echo_ranging_ctrl.sv
// tb/tb_echo_ranging_ctrl.sv - bench for echo_ranging_ctrl with an emulated capture block and result model
module tb_echo_ranging_ctrl;

    localparam int OL = 8;
    localparam int TW = 16;
    localparam int TC = 10;
    localparam int TO = 100;
    localparam int HO = 20;
`ifdef UDAR_CTRL_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cont_en;
    logic          cap_done;
    logic [OL-1:0] cap_cnt;
    logic          trig;
    logic          busy;
    logic [OL-1:0] result_data;
    logic          result_timeout;
    logic          result_valid;
    logic          result_ready;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int avg_q[$];
    bit drop_cont;
    bit r;

    echo_ranging_ctrl #(
        .OUT_LEN(OL), .TMR_W(TW), .TRIG_CYCLES(TC),
        .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont_en(cont_en),
        .cap_done(cap_done), .cap_cnt(cap_cnt), .trig(trig), .busy(busy),
        .result_data(result_data), .result_timeout(result_timeout),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One launch-to-idle measurement. kind 0: echo of w cycles after d cycles (w > TO means stuck);
    // kind 1: no echo at all. Cycle k counts negedges from the first one with trig low again.
    task automatic measure(input bit use_start, input int kind, input int d, input int w,
                           input int c, output bit exp_res);
        int lat, tw, fv, kd, kend, s;
        bit to;
        logic [OL-1:0] exp_d;
        to   = (kind == 1) || (w > TO);
        kd   = (kind == 1) ? TO : (to ? d + 1 + TO : d + 2 + w);
        kend = kd + HO;
        if (to) begin
            exp_d = '1;
            exp_res = 1'b1;
            avg_q.delete();
        end else if (AVG) begin
            avg_q.push_back(c);
            s = 0;
            foreach (avg_q[i]) s += avg_q[i];
            exp_d = OL'(s / 4);
            exp_res = (avg_q.size() == 4);
            if (exp_res) avg_q.delete();
        end else begin
            exp_d = OL'(c);
            exp_res = 1'b1;
        end

        if (use_start) start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!trig && lat < 60);
        chk("launch_latency", lat, 1);
        if (!trig) begin
            exp_res = 1'b0;
            return;
        end
        tw = 0;
        while (trig && tw < 60) begin
            tw++;
            @(negedge clk);
        end
        chk("trig_width", tw, TC);

        fv = -1;
        for (int k = 0; k <= kend; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0 && drop_cont) cont_en = 1'b0;
            if (result_valid && fv < 0) fv = k;
            if (k == kd && exp_res) begin
                chk("result_data", result_data, exp_d);
                chk("result_timeout", result_timeout, to);
            end
            if (k == kd + 1 && exp_res) chk("valid_after_edge", result_valid, !result_ready);
            if (k == kend - 1) chk("busy_holdoff", busy, 1);
            if (k == kend) begin
                chk("busy_idle", busy, 0);
                if (exp_res && !result_ready) begin
                    chk("valid_held", result_valid, 1);
                    chk("data_stable", result_data, exp_d);
                end
            end
            if (kind == 0) begin
                if (k == d) begin
                    cap_done = 1'b0;
                    cap_cnt  = OL'($urandom);
                end
                if (k == (to ? kd : d + w)) begin
                    cap_done = 1'b1;
                    cap_cnt  = OL'(c);
                end
            end
        end
        chk("first_valid_cycle", fv, exp_res ? kd : -1);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        chk("accept_clears", result_valid, 0);
        result_ready = 1'b0;
    endtask

    task automatic idle_watch(input int n, input string tag);
        int hi;
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (trig || busy) hi++;
        end
        chk(tag, hi, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cont_en = 1'b0; cap_done = 1'b1;
        cap_cnt = '0; result_ready = 1'b0; drop_cont = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_data", result_data, 0);
        chk("rst_timeout", result_timeout, 0);
        rst = 1'b0;
        @(negedge clk);

        // single shot, held result, then accept
        measure(1'b1, 0, 3, 25, 25, r);
        if (r) accept();

        result_ready = 1'b1;
        measure(1'b1, 1, 0, 0, 0, r);

        // capture busy blocks launch; stuck echo times out; timing boundaries
        cap_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle_watch(15, "start_ignored_cap_busy");
        cap_done = 1'b1;
        measure(1'b1, 0, 5, TO + 30, 7, r);
        measure(1'b1, 0, TO - 1, 5, 200, r);
        measure(1'b1, 0, 2, TO, 255, r);
        measure(1'b1, 0, 2, TO + 1, 9, r);

        // free running, then backpressure stall, then cont_en drop mid-measurement
        cont_en = 1'b1;
        repeat (3) measure(1'b0, 0, $urandom_range(0, 20), $urandom_range(1, 40),
                           $urandom_range(0, 255), r);
        result_ready = 1'b0;
        measure(1'b0, 1, 0, 0, 0, r);
        idle_watch(40, "stall_no_relaunch");
        accept();
        result_ready = 1'b1;
        drop_cont = 1'b1;
        measure(1'b0, 1, 0, 0, 0, r);
        drop_cont = 1'b0;
        idle_watch(30, "no_relaunch_after_cont_off");

        // asynchronous reset during TRIG
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("trig_before_rst", trig, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_trig", trig, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge clk);
        chk("rst_mid_data", result_data, 0);
        chk("rst_mid_timeout", result_timeout, 0);
        rst = 1'b0;
        avg_q.delete();

        // asynchronous reset during WAIT_FALL
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (TC) @(negedge clk);
        cap_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_wait_fall", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_wf_trig", trig, 0);
        chk("rst_wf_busy", busy, 0);
        chk("rst_wf_valid", result_valid, 0);
        @(negedge clk);
        cap_done = 1'b1;
        rst = 1'b0;
        avg_q.delete();
        measure(1'b1, 0, 4, 30, 77, r);

        // averaging sequence (plain per-measurement results when averaging is off)
        measure(1'b1, 0, 1, 10, 10, r);
        measure(1'b1, 0, 1, 11, 11, r);
        measure(1'b1, 0, 1, 12, 12, r);
        measure(1'b1, 0, 1, 14, 14, r);
        measure(1'b1, 0, 1, 10, 10, r);
        measure(1'b1, 1, 0, 0, 0, r);
        repeat (4) measure(1'b1, 0, $urandom_range(0, 10), $urandom_range(1, 30),
                           $urandom_range(0, 255), r);

        // random mix
        for (int i = 0; i < 8; i++) begin
            int kind, w;
            kind = ($urandom_range(0, 5) == 0) ? 1 : 0;
            w = ($urandom_range(0, 4) == 0) ? TO + $urandom_range(1, 20) : $urandom_range(1, 60);
            measure(1'b1, kind, $urandom_range(0, 30), w, $urandom_range(0, 255), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
